// File: rtl/fifo_uart_pkg.sv
// Shared types and sizes for the nibble FIFO UART transmitter.
// Frame layout: start bit, NIBBLE_W data bits (LSB first), optional parity bit, stop bit(s).
package fifo_uart_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

    // Serial bit slots in one frame.
    function automatic int frame_bits(input int parity_en, input int stop_bits);
        return 1 + NIBBLE_W + parity_en + stop_bits;
    endfunction

    localparam int FRAME_BITS_DEFAULT = frame_bits(1, 1);

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter for the serial transmitter.
// o_bit_tick marks the last clk of a bit; o_pre_tick marks the clk just before it.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear || o_bit_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_bit_tick = (r_count == CNT_W'(CLKS_PER_BIT - 1));
    assign o_pre_tick = (r_count == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/fifo_nibble_uart_tx.sv
// Drains the nibble FIFO one entry per frame and serialises it on tx.
// All outputs are registered; the FSM computes next values, one flop stage holds them.
module fifo_nibble_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                fifo_empty,
    input  logic [NIBBLE_W-1:0] fifo_rd_data,
    output logic                fifo_rd_en,
    output logic                tx,
    output logic                busy,
    output logic                frame_done
);

    state_t              r_state;
    state_t              w_state_next;
    logic [NIBBLE_W-1:0] r_shift;
    logic [NIBBLE_W-1:0] w_shift_next;
    logic                r_parity;
    logic                w_parity_next;
    logic [1:0]          r_bit_cnt;
    logic [1:0]          w_bit_cnt_next;
    logic                r_tx;
    logic                w_tx_next;
    logic                r_rd_en;
    logic                w_rd_en_next;
    logic                r_busy;
    logic                w_busy_next;
    logic                r_done;
    logic                w_done_next;
    logic                w_timer_clr;
    logic                w_bit_tick;
    logic                w_pre_tick;
    logic                w_last_stop;

    // Counter restarts on every state entry so each state sees a full bit period.
    assign w_timer_clr = (w_state_next != r_state) || (r_state == ST_IDLE);
    assign w_last_stop = (r_bit_cnt == 2'(STOP_BITS - 1));

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_timer_clr),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    // NOTE: the shift register and parity flop are reset too, so a mid-frame abort leaves no stale data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
            r_rd_en   <= w_rd_en_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
        end
    end

    // NOTE: every signal gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_rd_en_next   = 1'b0;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_next   = 1'b1;
                w_busy_next = 1'b0;
                if (ena && !fifo_empty) begin
                    w_state_next = ST_REQ;
                    w_rd_en_next = 1'b1;
                    w_busy_next  = 1'b1;
                end
            end
            ST_REQ: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                w_shift_next  = fifo_rd_data;
                w_parity_next = ^fifo_rd_data;
                w_tx_next     = 1'b0;
                w_state_next  = ST_START;
            end
            ST_START: begin
                if (w_bit_tick) begin
                    w_state_next   = ST_DATA;
                    w_tx_next      = r_shift[0];
                    w_bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (w_bit_tick) begin
                    if (r_bit_cnt == 2'(NIBBLE_W - 1)) begin
                        w_bit_cnt_next = '0;
                        if (PARITY_EN != 0) begin
                            w_state_next = ST_PARITY;
                            w_tx_next    = r_parity;
                        end else begin
                            w_state_next = ST_STOP;
                            w_tx_next    = 1'b1;
                        end
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 2'd1;
                        w_shift_next   = r_shift >> 1;
                        w_tx_next      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_tick) begin
                    w_state_next   = ST_STOP;
                    w_tx_next      = 1'b1;
                    w_bit_cnt_next = '0;
                end
            end
            ST_STOP: begin
                w_tx_next = 1'b1;
                // frame_done is registered, so raise it one clk ahead of the final stop cycle.
                if (w_last_stop && w_pre_tick) begin
                    w_done_next = 1'b1;
                end
                if (w_bit_tick) begin
                    if (w_last_stop) begin
                        w_state_next = ST_IDLE;
                        w_busy_next  = 1'b0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 2'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign tx         = r_tx;
    assign fifo_rd_en = r_rd_en;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule

// File: tb/tb_fifo_nibble_uart_tx.sv
// Directed bench for fifo_nibble_uart_tx: FIFO models with a 1-cycle registered read,
// line-level frame capture against hand-computed bit patterns.
module tb_fifo_nibble_uart_tx;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // FIFO model for the default-parameter DUT
    logic [3:0] mem [0:31];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [3:0] fifo_rd_data = 4'h0;
    logic       fifo_empty;
    logic       fifo_rd_en, tx, busy, frame_done;
    int         rd_cnt = 0;
    int         rd_bad = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fifo_empty) rd_bad <= rd_bad + 1;
            else begin
                fifo_rd_data <= mem[rd_ptr];
                rd_ptr       <= rd_ptr + 1;
            end
        end
    end

    // FIFO model for the no-parity DUT
    logic [3:0] np_mem [0:7];
    int         np_wr_ptr = 0;
    int         np_rd_ptr = 0;
    logic [3:0] np_rd_data = 4'h0;
    logic       np_empty;
    logic       np_rd_en, np_tx, np_busy, np_done;
    int         np_rd_cnt = 0;
    int         np_rd_bad = 0;

    assign np_empty = (np_wr_ptr == np_rd_ptr);

    always @(posedge clk) begin
        if (np_rd_en) begin
            np_rd_cnt <= np_rd_cnt + 1;
            if (np_empty) np_rd_bad <= np_rd_bad + 1;
            else begin
                np_rd_data <= np_mem[np_rd_ptr];
                np_rd_ptr  <= np_rd_ptr + 1;
            end
        end
    end

    fifo_nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    fifo_nibble_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) dut_np (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .fifo_empty   (np_empty),
        .fifo_rd_data (np_rd_data),
        .fifo_rd_en   (np_rd_en),
        .tx           (np_tx),
        .busy         (np_busy),
        .frame_done   (np_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic np_push(input logic [3:0] d);
        np_mem[np_wr_ptr] = d;
        np_wr_ptr = np_wr_ptr + 1;
    endtask

    function automatic logic line_tx(input bit sel);
        return sel ? np_tx : tx;
    endfunction

    // Counts idle-high samples until the start bit appears; current sample included.
    task automatic wait_start(input bit sel, input int budget, output int idle);
        idle = 0;
        while (line_tx(sel) !== 1'b0 && idle < budget) begin
            idle++;
            tick();
        end
        if (idle >= budget) check("start_timeout", 32'd1, 32'd0);
    endtask

    // Called with the current sample in the first START cycle; returns in the cycle after the frame.
    task automatic frame_checks(input string tag, input bit sel, input int nbits, input logic [7:0] exp_bits);
        logic [7:0] bits;
        int unstable, done_pos, done_cnt, busy_cyc;
        logic v;
        bits = 8'h00;
        unstable = 0;
        done_pos = -1;
        done_cnt = 0;
        busy_cyc = 0;
        for (int cyc = 0; cyc < nbits * CPB; cyc++) begin
            v = line_tx(sel);
            if (cyc % CPB == 0) bits[cyc / CPB] = v;
            else if (v !== bits[cyc / CPB]) unstable++;
            if ((sel ? np_done : frame_done) === 1'b1) begin
                done_cnt++;
                done_pos = cyc;
            end
            if ((sel ? np_busy : busy) === 1'b1) busy_cyc++;
            tick();
        end
        check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_pos"}, done_pos, nbits * CPB - 1);
        check({tag, "_busy_cyc"}, busy_cyc, nbits * CPB);
        check({tag, "_end_tx"}, 32'(line_tx(sel)), 32'd1);
        check({tag, "_end_busy"}, 32'(sel ? np_busy : busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idle;

        // Reset state
        rst_n = 1'b0;
        ena   = 1'b0;
        tick();
        tick();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_np_tx", 32'(np_tx), 32'd1);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick();

        // Single 0xA: latency and frame 0,0,1,0,1,0(par),1
        push(4'hA);
        tick();
        check("lat_rd_en_hi", 32'(fifo_rd_en), 32'd1);
        check("lat_busy_hi", 32'(busy), 32'd1);
        tick();
        check("lat_rd_en_lo", 32'(fifo_rd_en), 32'd0);
        check("lat_tx_idle", 32'(tx), 32'd1);
        tick();
        check("lat_tx_fall", 32'(tx), 32'd0);
        frame_checks("a", 1'b0, 7, 8'h54);
        check("a_pops", rd_cnt, 1);

        // Two nibbles back to back: 0xA then 0xC (0,0,0,1,1,0,1)
        push(4'hA);
        push(4'hC);
        wait_start(1'b0, 20, idle);
        frame_checks("b2b1", 1'b0, 7, 8'h54);
        wait_start(1'b0, 20, idle);
        check("b2b_gap", idle, 3);
        frame_checks("b2b2", 1'b0, 7, 8'h58);
        check("b2b_pops", rd_cnt, 3);

        // Odd weight: 0x7 -> 0,1,1,1,0,1(par),1
        push(4'h7);
        wait_start(1'b0, 20, idle);
        frame_checks("par7", 1'b0, 7, 8'h6E);

        // ena dropped mid-frame: 0x5 completes, 0x3 waits until ena returns
        push(4'h5);
        wait_start(1'b0, 20, idle);
        ena = 1'b0;
        push(4'h3);
        frame_checks("ena5", 1'b0, 7, 8'h4A);
        repeat (20) tick();
        check("ena_off_pops", rd_cnt, 5);
        check("ena_off_tx", 32'(tx), 32'd1);
        check("ena_off_busy", 32'(busy), 32'd0);
        ena = 1'b1;
        wait_start(1'b0, 20, idle);
        frame_checks("ena3", 1'b0, 7, 8'h46);
        check("ena_on_pops", rd_cnt, 6);

        // Reset in the middle of DATA
        push(4'h9);
        wait_start(1'b0, 20, idle);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_rst_idle_tx", 32'(tx), 32'd1);
        check("mid_rst_pops", rd_cnt, 7);
        push(4'h6);
        wait_start(1'b0, 20, idle);
        frame_checks("post_rst6", 1'b0, 7, 8'h4C);
        check("post_rst_pops", rd_cnt, 8);

        // No-parity variant: 0xA -> 0,0,1,0,1,1 in 24 cycles
        np_push(4'hA);
        wait_start(1'b1, 20, idle);
        frame_checks("np_a", 1'b1, 6, 8'h34);
        check("np_pops", np_rd_cnt, 1);

        check("pop_while_empty", rd_bad, 0);
        check("np_pop_while_empty", np_rd_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
